// File: rtl/mux_nto1_scan.sv
// Registered N:1 multiplexer with valid/ready output stage and an optional
// auto-scan sequencer, compiled in when MUX_SCAN_EN is defined.
module mux_nto1_scan #(
  parameter  int NUM_CH  = 16,
  parameter  int DATA_W  = 1,
  parameter  int DWELL_W = 8,
  localparam int SEL_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] mux_inp,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     sel_vld,
  input  logic                     scan_mode,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        mux_out,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     sel_err
);

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  logic [DATA_W-1:0] r_mux_out;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_out_vld;
  logic              r_sel_err;

  logic              w_slot_free;
  logic              w_sel_in_range;
  logic              w_dir_req;
  logic              w_dir_cap;
  logic              w_scan_cap;
  logic              w_cap;
  logic [SEL_W-1:0]  w_cap_ch;
  logic [DATA_W-1:0] w_cap_data;

  assign w_slot_free    = !r_out_vld || out_rdy;
  assign w_sel_in_range = ({1'b0, sel} < NUM_CH_L);

`ifdef MUX_SCAN_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_DWELL  = 2'd2;

  logic [1:0]         r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [DWELL_W-1:0] r_cnt;

  logic               w_found;
  logic [SEL_W-1:0]   w_found_idx;
  logic [SEL_W-1:0]   w_ptr_nxt;

  // Wrapping priority search: lowest enabled channel at or after the pointer.
  always_comb begin
    w_found     = 1'b0;
    w_found_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int sum;
      int idx;
      sum         = int'(r_ptr) + k;
      idx         = (sum >= NUM_CH) ? (sum - NUM_CH) : sum;
      w_found     = w_found | ch_mask[idx];
      w_found_idx = ch_mask[idx] ? SEL_W'(idx) : w_found_idx;
    end
  end

  assign w_ptr_nxt  = (w_found_idx == SEL_W'(NUM_CH - 1)) ? '0
                                                          : (w_found_idx + SEL_W'(1));
  assign w_scan_cap = (r_state == S_SAMPLE) && scan_mode && w_found && w_slot_free;
  assign w_dir_req  = (r_state == S_IDLE) && sel_vld;

  // Scan sequencer: pointer, dwell counter and mode state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_mode) begin
            r_state <= S_SAMPLE;
            r_ptr   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SAMPLE: begin
          if (!scan_mode) begin
            r_state <= S_IDLE;
          end else if (w_scan_cap) begin
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= dwell;
            r_state <= (dwell == '0) ? S_SAMPLE : S_DWELL;
          end else begin
            r_state <= S_SAMPLE;
          end
        end
        S_DWELL: begin
          // The count latched at capture runs out here; live dwell is ignored.
          if (!scan_mode) begin
            r_state <= S_IDLE;
          end else if (r_cnt <= DWELL_W'(1)) begin
            r_state <= S_SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt - DWELL_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_cap_ch = w_scan_cap ? w_found_idx : sel;
`else
  logic w_unused_scan;

  assign w_unused_scan = ^{scan_mode, ch_mask, dwell};
  assign w_scan_cap    = 1'b0;
  assign w_dir_req     = sel_vld;
  assign w_cap_ch      = sel;
`endif

  assign w_dir_cap = w_dir_req && w_sel_in_range && w_slot_free;
  assign w_cap     = w_dir_cap || w_scan_cap;

  // One-hot AND-OR data select keyed on the capture channel.
  always_comb begin
    w_cap_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cap_data = w_cap_data
                 | (mux_inp[i*DATA_W +: DATA_W] & {DATA_W{(w_cap_ch == SEL_W'(i))}});
    end
  end

  // Output stage: capture on a free slot, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mux_out <= '0;
      r_out_ch  <= '0;
      r_out_vld <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_dir_req && !w_sel_in_range;
      if (w_cap) begin
        r_mux_out <= w_cap_data;
        r_out_ch  <= w_cap_ch;
        r_out_vld <= 1'b1;
      end else if (out_rdy) begin
        r_out_vld <= 1'b0;
      end else begin
        r_out_vld <= r_out_vld;
      end
    end
  end

  assign mux_out = r_mux_out;
  assign out_ch  = r_out_ch;
  assign out_vld = r_out_vld;
  assign sel_err = r_sel_err;

endmodule

// File: doc/mux_nto1_scan.md
# mux_nto1_scan

Parametrised, registered N:1 multiplexer. It is the successor to the fixed 16:1 combinational mux in the CLB resource set. It adds three things: configurable channel count and data width, a valid/ready output stage that holds data under backpressure, and an optional auto-scan sequencer that walks the enabled channels with a programmable dwell. It sits between a bank of parallel sources (status lines, sensor words) and a single serial consumer.

## Interface
Parameters:
- NUM_CH, 16: number of input channels, ≥2.
- DATA_W, 1: width of each channel, ≥1.
- DWELL_W, 8: width of the dwell count.
- SEL_W, derived as $clog2(NUM_CH): select width. Localparam, not overridable.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mux_inp  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- sel  in  SEL_W  direct-mode channel select.
- sel_vld  in  1  direct-mode capture request.
- scan_mode  in  1  1 = auto-scan, 0 = direct.
- ch_mask  in  NUM_CH  scan enable per channel; bit i = channel i.
- dwell  in  DWELL_W  idle cycles between scan captures.
- mux_out  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  channel index of mux_out.
- out_vld  out  1  mux_out/out_ch valid.
- out_rdy  in  1  consumer accepts.
- sel_err  out  1  one-cycle pulse when a direct select is out of range.

## Operation
- **Slot free:** defined as `!out_vld || out_rdy`. A capture loads mux_out and out_ch and sets out_vld.
- **Transfer:** occurs when out_vld and out_rdy are both high. After a transfer with no capture in the same cycle, out_vld clears.
- **Backpressure:** while out_vld=1 and out_rdy=0, mux_out and out_ch stay stable. No capture occurs and no request is queued.
- **FSM states:** IDLE (direct), SCAN_SAMPLE, SCAN_DWELL.
- **IDLE:**
  - Capture occurs on sel_vld with a free slot. The register loads mux_inp[sel] and out_ch=sel.
  - If sel ≥ NUM_CH, sel_err pulses for 1 cycle and no capture occurs. This check applies even when the slot is not free.
  - If sel_vld is high while the slot is not free, the request is dropped. The source must hold sel_vld until the slot is free.
  - scan_mode=1 moves the FSM to SCAN_SAMPLE with the scan pointer set to 0.
- **SCAN_SAMPLE:**
  - Search ch_mask for the lowest enabled channel ≥ ptr, wrapping from NUM_CH-1 to 0.
  - If a channel is found and the slot is free: capture it, set ptr = found+1 (mod NUM_CH), and latch dwell into the counter.
  - Next state after a capture is SCAN_DWELL, or stay in SCAN_SAMPLE if dwell=0.
  - If the slot is not free, stall. Data is sampled at the capture cycle, never earlier.
  - If ch_mask = 0, no capture occurs and the FSM stays in SCAN_SAMPLE.
- **SCAN_DWELL:** the counter decrements each cycle. When it reaches 1, return to SCAN_SAMPLE.
- **Leaving scan:** scan_mode=0 in either scan state returns the FSM to IDLE next cycle. Held output data remains until transferred. sel_vld is ignored in scan states.
- **Input sampling:** ch_mask and dwell are sampled live. A mid-dwell change to dwell does not affect the running count.

## Timing
- **Reset values:** mux_out=0, out_ch=0, out_vld=0, sel_err=0. Internally, state=IDLE, ptr=0, counter=0.
- **Reset mid-operation:** held data is discarded.
- **Latency:** capture condition in cycle t gives mux_out/out_vld valid in cycle t+1.
- **Throughput, direct mode:** with sel_vld and out_rdy held high, one capture per cycle.
- **Throughput, scan mode:** with out_rdy held high, consecutive captures are exactly dwell+1 cycles apart.
- **Scan entry:** first capture occurs 2 cycles after scan_mode rises. That is 1 cycle to enter SCAN_SAMPLE, then the capture.
- **Simultaneous transfer and capture:** out_vld stays 1 and the new data replaces the old. There is no bubble.
- **sel_err timing:** asserted in the cycle after the offending sel_vld, and never coincident with an out_vld rise from that request.

## Configuration
- Macro: MUX_SCAN_EN.
- **Defined:** full behaviour as described above.
- **Undefined:**
  - The FSM reduces to IDLE.
  - The scan_mode, ch_mask and dwell ports remain present but are ignored.
  - The block is a direct registered mux with handshake.
  - The scan pointer and dwell counter are not synthesised.

## Test plan
- **Reset:** drive rst_n=0 for 3 cycles with all inputs toggling. Every output must be 0 throughout.
- **Direct mode:** NUM_CH=16, DATA_W=8, each channel i = 8'hA0+i, out_rdy=1. Sweep sel 0..15 with sel_vld=1. Expect mux_out=8'hA0+sel and out_ch=sel one cycle later, back-to-back with no gaps.
- **Out-of-range:** NUM_CH=12, sel=13, sel_vld=1. Expect a single sel_err pulse, out_vld unchanged and mux_out unchanged.
- **Backpressure:** capture channel 3, then hold out_rdy=0 for 5 cycles while changing mux_inp and requesting sel=7. mux_out must stay at the channel 3 value. After out_rdy=1 and a renewed sel_vld, expect the channel 7 value one cycle later.
- **Scan (MUX_SCAN_EN):** ch_mask=16'h8421, dwell=2, out_rdy=1. Expect out_ch sequence 0, 5, 10, 15, 0 with captures 3 cycles apart. Then set ch_mask=0: no further captures.
- **Mode exit:** during SCAN_DWELL, drop scan_mode with out_vld=1 and out_rdy=0. Held data must persist, the FSM must be in IDLE next cycle, and a subsequent sel_vld must be served once the slot frees.
